imsic_intp_file: RTL
====================

IMSIC_INTP_FILE -- requirements
Module: imsic_intp_file

Interface
REQ-001 SHALL have parameter NrSources, default 64, meaning number of interrupt identities (multiple of 32, 64..2048); identity 0 is reserved.
REQ-002 SHALL have derived parameters NrSourcesW = $clog2(NrSources), NrChunks = NrSources/32 and ChunkW = max(1,$clog2(NrChunks)).
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 ni_rst  input  1  reset, synchronous, active-low.
REQ-005 i_setipnum  input  NrSourcesW  identity to mark pending; one regmap output slice.
REQ-006 i_setipnum_we  input  1  setipnum strobe; one regmap write-enable bit.
REQ-007 i_eidelivery  input  1  interrupt delivery enable.
REQ-008 i_eithreshold  input  NrSourcesW  priority threshold; 0 means no threshold.
REQ-009 i_reg_we / i_reg_re  input  1 each  register write / read strobe.
REQ-010 i_reg_sel  input  1  0 selects eip array, 1 selects eie array.
REQ-011 i_reg_idx  input  ChunkW  32-bit word index; bit n of word k is identity 32k+n.
REQ-012 i_reg_wdata  input  32  full-word write data.
REQ-013 o_reg_rdata  output  32  read data, registered.
REQ-014 i_claim  input  1  claim the current o_topei.
REQ-015 o_topei  output  NrSourcesW  highest-priority pending-and-enabled identity, or 0.
REQ-016 o_irq  output  1  interrupt request to hart.

Function
REQ-017 Lower identity number SHALL mean higher priority.
REQ-018 A set event SHALL occur when i_setipnum_we=1 and 0 < i_setipnum < NrSources; other values are ignored.
REQ-019 Bit 0 of eip and eie SHALL read 0 and ignore writes.
REQ-020 Next eip SHALL be: register write applied first, then claim clear, then set OR-ed in, so a set wins over a claim or register clear of the same bit.
REQ-021 A claim SHALL clear eip[o_topei] only when o_topei != 0; a claim with o_topei = 0 has no effect.
REQ-022 o_reg_rdata SHALL be loaded at the edge where i_reg_re=1 with the pre-update word selected by i_reg_sel/i_reg_idx; otherwise it holds.
REQ-023 i_reg_idx >= NrChunks SHALL ignore writes and return 0 on reads.
REQ-024 Scan FSM states: IDLE, SCAN; chunk pointer ChunkW bits; candidate register NrSourcesW bits.
REQ-025 Modification event: any change to eip, eie, i_eithreshold or a claim.
REQ-026 IDLE: on a modification event -> SCAN with pointer 0 and candidate 0.
REQ-027 SCAN: each cycle evaluates chunk[pointer] = eip & eie; lowest set bit n qualifies if threshold=0 or 32*pointer+n < threshold; candidate is kept if already nonzero.
REQ-028 SCAN on the last chunk: o_topei <= final candidate, then -> IDLE unless a modification event occurred in that same cycle.
REQ-029 A modification event during SCAN SHALL restart the scan at pointer 0 with candidate 0.
REQ-030 o_topei SHALL be correct at most NrChunks+1 cycles after the edge registering the last modification.
REQ-031 A claim SHALL force o_topei to 0 at the next edge until the rescan publishes.
REQ-032 o_irq SHALL be registered and equal i_eidelivery && (o_topei != 0), one cycle after either changes.
REQ-033 o_topei SHALL be computed regardless of i_eidelivery.

Reset
REQ-034 While ni_rst=0 at an edge: eip=0, eie=0, o_topei=0, o_irq=0, o_reg_rdata=0, state=IDLE, pointer=0, candidate=0.
REQ-035 Reset SHALL abort an in-progress scan; the first modification after reset starts a fresh scan.

Verification
REQ-036 NrSources=64: eie word0=0xFFFF_FFFF, setipnum=5 -> o_topei=5 within 3 cycles; o_irq=1 one cycle later with eidelivery=1.
REQ-037 Pending 5 and 40 with both enabled, claim -> o_topei=0 next cycle, then o_topei=40; second claim -> o_topei=0, o_irq=0.
REQ-038 Threshold=5, pending 5 and 40 enabled -> o_topei=0; threshold=41 -> o_topei=5.
REQ-039 Same cycle: claim with o_topei=7 plus setipnum=7 -> eip bit 7 remains 1, o_topei returns to 7.
REQ-040 setipnum=0 and setipnum=64 -> no eip change, no scan; eip write 0x1 to word0 -> reads back 0x0.
REQ-041 ni_rst=0 during SCAN -> all outputs 0 next cycle; eip/eie read back 0.

Source files
------------

// File: rtl/imsic_intp_file.sv
// Purpose: IMSIC interrupt file. Holds the eip/eie arrays and finds the top pending-and-enabled identity.
// Latency: o_topei settles within NrChunks+1 cycles of the last change; o_reg_rdata 1 cycle; o_irq 1 cycle after o_topei.
// Backpressure: none; setipnum, register and claim strobes are accepted on every cycle.
module imsic_intp_file #(
  parameter int NrSources  = 64,
  parameter int NrSourcesW = $clog2(NrSources),
  parameter int NrChunks   = NrSources / 32,
  parameter int ChunkW     = (NrChunks > 1) ? $clog2(NrChunks) : 1
) (
  input  logic                  i_clk,
  input  logic                  ni_rst,
  input  logic [NrSourcesW-1:0] i_setipnum,
  input  logic                  i_setipnum_we,
  input  logic                  i_eidelivery,
  input  logic [NrSourcesW-1:0] i_eithreshold,
  input  logic                  i_reg_we,
  input  logic                  i_reg_re,
  input  logic                  i_reg_sel,
  input  logic [ChunkW-1:0]     i_reg_idx,
  input  logic [31:0]           i_reg_wdata,
  output logic [31:0]           o_reg_rdata,
  input  logic                  i_claim,
  output logic [NrSourcesW-1:0] o_topei,
  output logic                  o_irq
);

  // The word view is padded to a power of two so out-of-range indices read 0 and match no write.
  localparam int NrWords = 1 << ChunkW;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [NrSources-1:0]  eip, eie, eip_nxt, eie_nxt, set_mask, clr_mask;
  logic [NrSourcesW-1:0] thr_q;
  logic [31:0]           eip_w [NrWords];
  logic [31:0]           eie_w [NrWords];
  logic                  mod_evt;

  state_t                state, state_nxt;
  logic [ChunkW-1:0]     ptr, ptr_nxt;
  logic [NrSourcesW-1:0] cand, cand_nxt, cand_scan, hit_id;
  logic [31:0]           chunk;
  logic [4:0]            lsb;
  logic                  lsb_vld, qual, last;

  for (genvar k = 0; k < NrWords; k++) begin : g_words
    if (k < NrChunks) begin : g_live
      assign eip_w[k] = eip[k*32 +: 32];
      assign eie_w[k] = eie[k*32 +: 32];
    end else begin : g_pad
      assign eip_w[k] = '0;
      assign eie_w[k] = '0;
    end
  end

  // Next eip/eie: register write first, then claim clear, then set; shifts past the top fall off, dropping out-of-range ids.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_setipnum_we) set_mask = NrSources'(1) << i_setipnum;
    if (i_claim)       clr_mask = NrSources'(1) << o_topei;
    eip_nxt = eip;
    eie_nxt = eie;
    if (i_reg_we) begin
      for (int k = 0; k < NrChunks; k++) begin
        if (i_reg_idx == ChunkW'(k)) begin
          if (i_reg_sel) eie_nxt[k*32 +: 32] = i_reg_wdata;
          else           eip_nxt[k*32 +: 32] = i_reg_wdata;
        end
      end
    end
    eip_nxt    = (eip_nxt & ~clr_mask) | set_mask;
    eip_nxt[0] = 1'b0;
    eie_nxt[0] = 1'b0;
  end

  assign mod_evt = (eip_nxt != eip) || (eie_nxt != eie) || (i_eithreshold != thr_q) || i_claim;

  // Scan step: lowest pending-and-enabled bit of the current chunk, filtered by the threshold.
  always_comb begin
    chunk   = eip_w[ptr] & eie_w[ptr];
    lsb_vld = 1'b0;
    lsb     = '0;
    for (int n = 31; n >= 0; n--) begin
      if (chunk[n]) begin
        lsb_vld = 1'b1;
        lsb     = 5'(n);
      end
    end
    hit_id    = NrSourcesW'({ptr, lsb});
    qual      = lsb_vld && ((i_eithreshold == '0) || (hit_id < i_eithreshold));
    cand_scan = (cand != '0) ? cand : (qual ? hit_id : '0);
    last      = (ptr == ChunkW'(NrChunks - 1));
  end

  // Scan FSM next state: any modification restarts from chunk 0 with an empty candidate.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cand_nxt  = cand;
    case (state)
      IDLE: begin
        if (mod_evt) begin
          state_nxt = SCAN;
          ptr_nxt   = '0;
          cand_nxt  = '0;
        end
      end
      SCAN: begin
        if (mod_evt) begin
          ptr_nxt  = '0;
          cand_nxt = '0;
        end else if (last) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          cand_nxt  = '0;
        end else begin
          ptr_nxt  = ptr + ChunkW'(1);
          cand_nxt = cand_scan;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
        cand_nxt  = '0;
      end
    endcase
  end

  // Scan FSM state register; reset aborts any scan in progress.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state <= IDLE;
      ptr   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cand  <= cand_nxt;
    end
  end

  // Arrays, read port and outputs; a claim zeroes o_topei until the rescan publishes.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      eip         <= '0;
      eie         <= '0;
      thr_q       <= '0;
      o_reg_rdata <= '0;
      o_topei     <= '0;
      o_irq       <= 1'b0;
    end else begin
      eip   <= eip_nxt;
      eie   <= eie_nxt;
      thr_q <= i_eithreshold;
      if (i_reg_re) o_reg_rdata <= i_reg_sel ? eie_w[i_reg_idx] : eip_w[i_reg_idx];
      if (i_claim)                   o_topei <= '0;
      else if ((state == SCAN) && last) o_topei <= cand_scan;
      o_irq <= i_eidelivery && (o_topei != '0);
    end
  end

endmodule
